// File: rtl/amm_trans_queue_gen_if.sv
// Bundle of command, compare-descriptor and Avalon-MM signals for amm_trans_queue_gen.
// Statistics outputs exist only when AMM_TRANS_STAT_EN is defined.
interface amm_trans_queue_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int BURST_W = 11
);
    logic [BURST_W-2:0]  burstcount_i;
    logic [1:0]          data_mode_i;
    logic [7:0]          data_ptrn_i;
    logic                trans_valid_i;
    logic [ADDR_W-1:0]   trans_addr_i;
    logic                trans_type_i;
    logic                trans_ready_o;
    logic                trans_busy_o;
    logic                cmp_error_i;
    logic                cmp_en_o;
    logic [ADDR_W-1:0]   cmp_addr_o;
    logic [BURST_W-2:0]  cmp_words_o;
    logic [1:0]          cmp_mode_o;
    logic [7:0]          cmp_ptrn_o;
    logic                waitrequest_i;
    logic [ADDR_W-1:0]   address_o;
    logic                read_o;
    logic                write_o;
    logic [DATA_W-1:0]   writedata_o;
    logic [BURST_W-1:0]  burstcount_o;
    logic [DATA_W/8-1:0] byteenable_o;
`ifdef AMM_TRANS_STAT_EN
    logic [31:0]         wr_beats_o;
    logic [31:0]         rd_cmds_o;
    logic [15:0]         flush_cnt_o;
`endif

    modport master (
        input  burstcount_i, data_mode_i, data_ptrn_i, trans_valid_i, trans_addr_i, trans_type_i,
        input  cmp_error_i, waitrequest_i,
        output trans_ready_o, trans_busy_o,
        output cmp_en_o, cmp_addr_o, cmp_words_o, cmp_mode_o, cmp_ptrn_o,
        output address_o, read_o, write_o, writedata_o, burstcount_o,
`ifdef AMM_TRANS_STAT_EN
        output wr_beats_o, rd_cmds_o, flush_cnt_o,
`endif
        output byteenable_o
    );

    modport slave (
        output burstcount_i, data_mode_i, data_ptrn_i, trans_valid_i, trans_addr_i, trans_type_i,
        output cmp_error_i, waitrequest_i,
        input  trans_ready_o, trans_busy_o,
        input  cmp_en_o, cmp_addr_o, cmp_words_o, cmp_mode_o, cmp_ptrn_o,
        input  address_o, read_o, write_o, writedata_o, burstcount_o,
`ifdef AMM_TRANS_STAT_EN
        input  wr_beats_o, rd_cmds_o, flush_cnt_o,
`endif
        input  byteenable_o
    );
endinterface

// File: rtl/amm_trans_queue_gen.sv
// Queued Avalon-MM burst transmitter with write-data generator and compare-descriptor output.
// Define AMM_TRANS_STAT_EN to add saturating beat/command/flush statistics counters.
module amm_trans_queue_gen #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int BURST_W   = 11,
    parameter int CMD_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    amm_trans_queue_gen_if.master bus
);
    localparam int DATA_B_W = DATA_W / 8;
    localparam int PTR_W    = $clog2(CMD_DEPTH);
    localparam int CNT_W    = BURST_W - 1;
    localparam int ENTRY_W  = 1 + ADDR_W + CNT_W + 2 + 8;
    localparam int unsigned DEPTH_U = CMD_DEPTH;
    localparam logic [PTR_W:0] FULL_CNT = DEPTH_U[PTR_W:0];
    localparam logic [1:0] MODE_RND = 2'd1;
    localparam logic [1:0] MODE_CNT = 2'd2;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WR = 2'd1, ST_RD = 2'd2} state_t;

    // XNOR-feedback shift; all-ones is its lock-up state, so the reset seed repeats.
    function automatic logic [7:0] lfsr_next(input logic [7:0] r);
        return {r[6:0], r[7] ^ r[1] ^ 1'b1};
    endfunction

    logic [ENTRY_W-1:0] q_mem_r [CMD_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]     count_r;

    state_t             state_r;
    logic [ADDR_W-1:0]  address_r;
    logic [BURST_W-1:0] burstcount_r;
    logic               read_r, write_r;
    logic [7:0]         data_byte_r;
    logic [CNT_W-1:0]   beat_cnt_r;
    logic [1:0]         cur_mode_r;
    logic [7:0]         cur_ptrn_r;
    logic [7:0]         lfsr_r;
    logic               cmp_en_r;
    logic [ADDR_W-1:0]  cmp_addr_r;
    logic [CNT_W-1:0]   cmp_words_r;
    logic [1:0]         cmp_mode_r;
    logic [7:0]         cmp_ptrn_r;

    logic               ready_s, empty_s, push_s, pop_s;
    logic               wr_accept_s, wr_last_s, rd_accept_s;
    logic [ENTRY_W-1:0] head_s;
    logic               head_type_s;
    logic [ADDR_W-1:0]  head_addr_s;
    logic [CNT_W-1:0]   head_bc_s;
    logic [1:0]         head_mode_s;
    logic [7:0]         head_ptrn_s;
    logic [7:0]         first_byte_s;

    assign ready_s     = (count_r != FULL_CNT);
    assign empty_s     = (count_r == {(PTR_W+1){1'b0}});
    assign push_s      = bus.trans_valid_i && ready_s && !bus.cmp_error_i;

    assign head_s      = q_mem_r[rd_ptr_r];
    assign head_type_s = head_s[ENTRY_W-1];
    assign head_addr_s = head_s[ENTRY_W-2 -: ADDR_W];
    assign head_bc_s   = head_s[CNT_W+9:10];
    assign head_mode_s = head_s[9:8];
    assign head_ptrn_s = head_s[7:0];
    assign first_byte_s = (head_mode_s == MODE_RND) ? lfsr_r : head_ptrn_s;

    assign wr_accept_s = (state_r == ST_WR) && write_r && !bus.waitrequest_i;
    assign wr_last_s   = wr_accept_s && (beat_cnt_r == {CNT_W{1'b0}});
    assign rd_accept_s = (state_r == ST_RD) && read_r && !bus.waitrequest_i;
    // A flush wins over any pop on the same edge, so nothing new starts after an error.
    assign pop_s       = !empty_s && !bus.cmp_error_i &&
                         ((state_r == ST_IDLE) || wr_last_s || rd_accept_s);

    // Command queue storage and occupancy.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < CMD_DEPTH; i++) begin
                q_mem_r[i] <= {ENTRY_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                q_mem_r[wr_ptr_r] <= {bus.trans_type_i, bus.trans_addr_i, bus.burstcount_i,
                                      bus.data_mode_i, bus.data_ptrn_i};
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (bus.cmp_error_i) begin
                rd_ptr_r <= wr_ptr_r;
                count_r  <= {(PTR_W+1){1'b0}};
            end else begin
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
                end
                count_r <= count_r + (PTR_W+1)'(push_s) - (PTR_W+1)'(pop_s);
            end
        end
    end

    // Burst FSM, bus outputs, data generator and compare descriptor.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r      <= ST_IDLE;
            address_r    <= {ADDR_W{1'b0}};
            burstcount_r <= {BURST_W{1'b0}};
            read_r       <= 1'b0;
            write_r      <= 1'b0;
            data_byte_r  <= 8'h00;
            beat_cnt_r   <= {CNT_W{1'b0}};
            cur_mode_r   <= 2'd0;
            cur_ptrn_r   <= 8'h00;
            lfsr_r       <= 8'hFF;
            cmp_en_r     <= 1'b0;
            cmp_addr_r   <= {ADDR_W{1'b0}};
            cmp_words_r  <= {CNT_W{1'b0}};
            cmp_mode_r   <= 2'd0;
            cmp_ptrn_r   <= 8'h00;
        end else begin
            cmp_en_r <= 1'b0;
            if (pop_s) begin
                address_r    <= head_addr_s;
                burstcount_r <= BURST_W'(head_bc_s) + BURST_W'(1'b1);
                if (head_type_s) begin
                    state_r <= ST_RD;
                    read_r  <= 1'b1;
                    write_r <= 1'b0;
                end else begin
                    state_r     <= ST_WR;
                    write_r     <= 1'b1;
                    read_r      <= 1'b0;
                    beat_cnt_r  <= head_bc_s;
                    cur_mode_r  <= head_mode_s;
                    cur_ptrn_r  <= head_ptrn_s;
                    data_byte_r <= first_byte_s;
                    cmp_en_r    <= 1'b1;
                    cmp_addr_r  <= head_addr_s;
                    cmp_words_r <= head_bc_s;
                    cmp_mode_r  <= head_mode_s;
                    cmp_ptrn_r  <= first_byte_s;
                    if (head_mode_s == MODE_RND) begin
                        lfsr_r <= lfsr_next(lfsr_r);
                    end
                end
            end else if (wr_last_s || rd_accept_s) begin
                state_r <= ST_IDLE;
                write_r <= 1'b0;
                read_r  <= 1'b0;
            end else if (wr_accept_s) begin
                beat_cnt_r <= beat_cnt_r - CNT_W'(1'b1);
                case (cur_mode_r)
                    MODE_RND: begin
                        data_byte_r <= lfsr_r;
                        lfsr_r      <= lfsr_next(lfsr_r);
                    end
                    MODE_CNT: data_byte_r <= data_byte_r + 8'd1;
                    default:  data_byte_r <= cur_ptrn_r;
                endcase
            end else if (state_r != ST_IDLE && state_r != ST_WR && state_r != ST_RD) begin
                state_r <= ST_IDLE;
                write_r <= 1'b0;
                read_r  <= 1'b0;
            end
        end
    end

`ifdef AMM_TRANS_STAT_EN
    logic [31:0] wr_beats_r, rd_cmds_r;
    logic [15:0] flush_cnt_r;

    // Saturating activity counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_beats_r  <= 32'd0;
            rd_cmds_r   <= 32'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            if (wr_accept_s && wr_beats_r != 32'hFFFF_FFFF) begin
                wr_beats_r <= wr_beats_r + 32'd1;
            end
            if (rd_accept_s && rd_cmds_r != 32'hFFFF_FFFF) begin
                rd_cmds_r <= rd_cmds_r + 32'd1;
            end
            if (bus.cmp_error_i && flush_cnt_r != 16'hFFFF) begin
                flush_cnt_r <= flush_cnt_r + 16'd1;
            end
        end
    end

    assign bus.wr_beats_o  = wr_beats_r;
    assign bus.rd_cmds_o   = rd_cmds_r;
    assign bus.flush_cnt_o = flush_cnt_r;
`endif

    assign bus.trans_ready_o = ready_s;
    assign bus.trans_busy_o  = !empty_s || (state_r != ST_IDLE);
    assign bus.cmp_en_o      = cmp_en_r;
    assign bus.cmp_addr_o    = cmp_addr_r;
    assign bus.cmp_words_o   = cmp_words_r;
    assign bus.cmp_mode_o    = cmp_mode_r;
    assign bus.cmp_ptrn_o    = cmp_ptrn_r;
    assign bus.address_o     = address_r;
    assign bus.read_o        = read_r;
    assign bus.write_o       = write_r;
    assign bus.writedata_o   = {DATA_B_W{data_byte_r}};
    assign bus.burstcount_o  = burstcount_r;
    assign bus.byteenable_o  = {DATA_B_W{1'b1}};
endmodule

// File: tb/tb_amm_trans_queue_gen.sv
// Scoreboard bench for amm_trans_queue_gen: directed commands push expected beats/descriptors,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_amm_trans_queue_gen;
    localparam int ADDR_W = 32, DATA_W = 64, BURST_W = 11, CMD_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    amm_trans_queue_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) bus ();

    amm_trans_queue_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
                          .CMD_DEPTH(CMD_DEPTH)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

    typedef struct { logic [31:0] addr; logic [10:0] bcount; logic [63:0] data; } beat_t;
    typedef struct { logic [31:0] addr; logic [9:0] words; logic [1:0] mode; logic [7:0] ptrn; } cmp_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_reads[$];
    cmp_t        exp_cmps[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cmp_seen = 0;
    logic [7:0]  m_lfsr = 8'hFF;

    function automatic logic [7:0] model_lfsr(input logic [7:0] r);
        return {r[6:0], r[7] ^ r[1] ^ 1'b1};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // track: 0 nothing expected, 1 full expectation, 2 descriptor only
    task automatic push_cmd(input logic typ, input logic [31:0] addr, input logic [9:0] bc,
                            input logic [1:0] mode, input logic [7:0] ptrn, input int track);
        logic [7:0] b, first;
        bus.trans_valid_i = 1'b1;
        bus.trans_type_i  = typ;
        bus.trans_addr_i  = addr;
        bus.burstcount_i  = bc;
        bus.data_mode_i   = mode;
        bus.data_ptrn_i   = ptrn;
        first = ptrn;
        if (track == 1 && typ) begin
            exp_reads.push_back(addr);
        end else if (track == 1) begin
            for (int i = 0; i <= int'(bc); i++) begin
                case (mode)
                    2'd1: begin b = m_lfsr; m_lfsr = model_lfsr(m_lfsr); end
                    2'd2: b = ptrn + 8'(i);
                    default: b = ptrn;
                endcase
                if (i == 0) first = b;
                exp_beats.push_back('{addr, {1'b0, bc} + 11'd1, {8{b}}});
            end
        end
        if (track != 0 && !typ) exp_cmps.push_back('{addr, bc, mode, first});
        tick();
        bus.trans_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.trans_busy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_fail++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, n);
        end
    endtask

    // Monitor: every accepted beat/read and every descriptor strobe is scored.
    initial begin
        beat_t       mb;
        logic [31:0] ma;
        cmp_t        mc;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.write_o && !bus.waitrequest_i) begin
                    if (exp_beats.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_wr_beat: addr %h data %h, required none", bus.address_o, bus.writedata_o);
                    end else begin
                        mb = exp_beats.pop_front();
                        check("wr_data", bus.writedata_o, mb.data);
                        check("wr_addr", 64'(bus.address_o), 64'(mb.addr));
                        check("wr_burstcount", 64'(bus.burstcount_o), 64'(mb.bcount));
                    end
                end
                if (bus.read_o && !bus.waitrequest_i) begin
                    if (exp_reads.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_read: addr %h, required none", bus.address_o);
                    end else begin
                        ma = exp_reads.pop_front();
                        check("rd_addr", 64'(bus.address_o), 64'(ma));
                    end
                end
                if (bus.cmp_en_o) begin
                    cmp_seen++;
                    if (exp_cmps.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_cmp: addr %h, required none", bus.cmp_addr_o);
                    end else begin
                        mc = exp_cmps.pop_front();
                        check("cmp_addr", 64'(bus.cmp_addr_o), 64'(mc.addr));
                        check("cmp_words", 64'(bus.cmp_words_o), 64'(mc.words));
                        check("cmp_mode", 64'(bus.cmp_mode_o), 64'(mc.mode));
                        check("cmp_ptrn", 64'(bus.cmp_ptrn_o), 64'(mc.ptrn));
                    end
                end
            end
        end
    end

    initial begin
        int cnt, n0;
        bus.trans_valid_i = 1'b0; bus.trans_type_i = 1'b0; bus.trans_addr_i = 32'h0;
        bus.burstcount_i = 10'd0; bus.data_mode_i = 2'd0; bus.data_ptrn_i = 8'h00;
        bus.cmp_error_i = 1'b0; bus.waitrequest_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.trans_ready_o), 64'd1);
        check("rst_busy", 64'(bus.trans_busy_o), 64'd0);
        check("rst_write", 64'(bus.write_o), 64'd0);
        check("rst_read", 64'(bus.read_o), 64'd0);
        check("rst_cmp_en", 64'(bus.cmp_en_o), 64'd0);
        check("rst_burstcount", 64'(bus.burstcount_o), 64'd0);
        check("rst_byteenable", 64'(bus.byteenable_o), 64'hFF);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // 1: single FIXED write burst
        n0 = cmp_seen;
        push_cmd(1'b0, 32'h100, 10'd3, 2'd0, 8'hA5, 1);
        cnt = 0;
        repeat (8) begin @(negedge clk); if (bus.write_o) cnt++; end
        check("t1_write_cycles", 64'(cnt), 64'd4);
        check("t1_cmp_count", 64'(cmp_seen - n0), 64'd1);
        wait_idle("t1");

        // 2: fill the queue under waitrequest, then release: no bubbles
        bus.waitrequest_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push_cmd(1'b0, 32'h200 + 32'(k * 16), 10'd1, 2'd0, 8'h11 * 8'(k + 1), 1);
        end
        check("t2_ready_full", 64'(bus.trans_ready_o), 64'd0);
        repeat (15) tick();
        check("t2_stall_addr", 64'(bus.address_o), 64'h200);
        check("t2_stall_data", bus.writedata_o, {8{8'h11}});
        check("t2_stall_write", 64'(bus.write_o), 64'd1);
        bus.waitrequest_i = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (bus.write_o && cnt < 40) begin cnt++; @(negedge clk); end
        check("t2_backtoback_beats", 64'(cnt), 64'd10);
        wait_idle("t2");

        // 3: RND bursts; 4: CNT with wrap
        push_cmd(1'b0, 32'h300, 10'd1, 2'd1, 8'h00, 1);
        push_cmd(1'b0, 32'h310, 10'd1, 2'd1, 8'h00, 1);
        wait_idle("t3");
        push_cmd(1'b0, 32'h400, 10'd3, 2'd2, 8'hFE, 1);
        wait_idle("t4");

        // 5: read held by waitrequest, write chained right after
        bus.waitrequest_i = 1'b1;
        push_cmd(1'b1, 32'h500, 10'd0, 2'd0, 8'h00, 1);
        push_cmd(1'b0, 32'h600, 10'd1, 2'd0, 8'h3C, 1);
        cnt = 0;
        repeat (3) begin @(negedge clk); if (bus.read_o) cnt++; end
        @(posedge clk); #1 bus.waitrequest_i = 1'b0;
        @(negedge clk); if (bus.read_o) cnt++;
        check("t5_read_cycles", 64'(cnt), 64'd4);
        @(negedge clk);
        check("t5_write_next", 64'(bus.write_o), 64'd1);
        check("t5_read_dropped", 64'(bus.read_o), 64'd0);
        wait_idle("t5");

        // 6: flush during beat 2 of 4 with two commands queued
        bus.waitrequest_i = 1'b1;
        push_cmd(1'b0, 32'h700, 10'd3, 2'd0, 8'h5A, 1);
        push_cmd(1'b0, 32'h710, 10'd1, 2'd0, 8'h01, 0);
        push_cmd(1'b0, 32'h720, 10'd1, 2'd0, 8'h02, 0);
        repeat (2) tick();
        bus.waitrequest_i = 1'b0;
        tick();
        bus.cmp_error_i = 1'b1;
        tick();
        bus.cmp_error_i = 1'b0;
        @(negedge clk);
        check("t6_beat3_write", 64'(bus.write_o), 64'd1);
        check("t6_queue_empty", 64'(bus.trans_ready_o), 64'd1);
        @(negedge clk);
        check("t6_beat4_write", 64'(bus.write_o), 64'd1);
        check("t6_beat4_busy", 64'(bus.trans_busy_o), 64'd1);
        @(negedge clk);
        check("t6_after_write", 64'(bus.write_o), 64'd0);
        check("t6_after_busy", 64'(bus.trans_busy_o), 64'd0);
        repeat (6) @(negedge clk);
        check("t6_beats_drained", 64'(exp_beats.size()), 64'd0);

        // 7: asynchronous reset mid-burst
        bus.waitrequest_i = 1'b1;
        push_cmd(1'b0, 32'h800, 10'd7, 2'd0, 8'h77, 2);
        cnt = 0;
        @(negedge clk);
        while (!bus.write_o && cnt < 20) begin cnt++; @(negedge clk); end
        check("t7_write_started", 64'(bus.write_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t7_async_write", 64'(bus.write_o), 64'd0);
        check("t7_async_busy", 64'(bus.trans_busy_o), 64'd0);
        bus.waitrequest_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        check("end_beats_left", 64'(exp_beats.size()), 64'd0);
        check("end_reads_left", 64'(exp_reads.size()), 64'd0);
        check("end_cmps_left", 64'(exp_cmps.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
